irom_arbiter: RTL and testbench

Two-port arbiter and read sequencer for the single instruction ROM. Shares the ROM between the instruction-fetch stage (port 0, `if_`) and a data-side read port (port 1, `dp_`) used for constant loads from code space and by the boot loader. It arbitrates requests every cycle, registers the winner's address, drives the ROM chip enable and address, and returns registered read data with fixed latency. The block sits between the pc/if logic, the mem stage, and `inst_rom`.

---
 rtl/irom_arbiter.sv | 137 +++++++++++++
 tb/tb_irom_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/irom_arbiter.sv
// rtl/irom_arbiter.sv - two-port (fetch/data) arbiter and fixed-latency read sequencer for the instruction ROM
// Round-robin arbitration when IROM_ARB_RR_EN is defined, otherwise fetch has fixed priority.
module irom_arbiter #(
    parameter int ROM_AW = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dp_req,
    input  logic [31:0] dp_addr,
    output logic        dp_gnt,
    output logic        dp_rvalid,
    output logic [31:0] dp_rdata,
    output logic        dp_err,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst
);

    logic        w_if_eff;
    logic        w_if_gnt;
    logic        w_dp_gnt;
    logic [31:0] w_sel_addr;
    logic        w_sel_err;
    logic        w_s1_kill;

    logic        r_s1_valid;
    logic        r_s1_port;
    logic [31:0] r_s1_addr;
    logic        r_s1_err;

    logic        r_if_rvalid;
    logic [31:0] r_if_rdata;
    logic        r_if_err;
    logic        r_dp_rvalid;
    logic [31:0] r_dp_rdata;
    logic        r_dp_err;

    // A flushed fetch request is treated as absent, so dp wins uncontested.
    assign w_if_eff = if_req & ~if_flush;

`ifdef IROM_ARB_RR_EN
    logic r_rr_ptr;

    always_comb begin
        w_if_gnt = 1'b0;
        w_dp_gnt = 1'b0;
        if (rst) begin
            w_if_gnt = w_if_eff & (~dp_req | ~r_rr_ptr);
            w_dp_gnt = dp_req & (~w_if_eff | r_rr_ptr);
        end
    end

    // After a contested grant the pointer favours the loser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_if_eff && dp_req) begin
            r_rr_ptr <= w_if_gnt;
        end
    end
`else
    always_comb begin
        w_if_gnt = 1'b0;
        w_dp_gnt = 1'b0;
        if (rst) begin
            w_if_gnt = w_if_eff;
            w_dp_gnt = dp_req & ~w_if_eff;
        end
    end
`endif

    assign w_sel_addr = w_dp_gnt ? dp_addr : if_addr;
    assign w_sel_err  = (w_sel_addr[1:0] != 2'b00) | ((w_sel_addr >> (ROM_AW + 2)) != 32'd0);

    // S1 fetch entries die here when a flush arrives while they are in flight.
    assign w_s1_kill  = if_flush & r_s1_valid & ~r_s1_port;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_port  <= 1'b0;
            r_s1_addr  <= 32'd0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_if_gnt | w_dp_gnt;
            if (w_if_gnt || w_dp_gnt) begin
                r_s1_port <= w_dp_gnt;
                r_s1_addr <= w_sel_addr;
                r_s1_err  <= w_sel_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_if_err    <= 1'b0;
            r_dp_rvalid <= 1'b0;
            r_dp_rdata  <= 32'd0;
            r_dp_err    <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dp_rvalid <= 1'b0;
            if (r_s1_valid && !w_s1_kill) begin
                if (r_s1_port) begin
                    r_dp_rvalid <= 1'b1;
                    r_dp_rdata  <= r_s1_err ? 32'd0 : rom_inst;
                    r_dp_err    <= r_s1_err;
                end else begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= r_s1_err ? 32'd0 : rom_inst;
                    r_if_err    <= r_s1_err;
                end
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign dp_gnt    = w_dp_gnt;
    assign rom_ce    = r_s1_valid & ~r_s1_err;
    assign rom_addr  = r_s1_addr;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign dp_rvalid = r_dp_rvalid;
    assign dp_rdata  = r_dp_rdata;
    assign dp_err    = r_dp_err;

endmodule

// File: tb/tb_irom_arbiter.sv
// tb/tb_irom_arbiter.sv - directed self-checking bench for irom_arbiter
module tb_irom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_flush = 1'b0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        dp_req = 1'b0;
    logic [31:0] dp_addr = 32'd0;
    logic        dp_gnt, dp_rvalid, dp_err;
    logic [31:0] dp_rdata;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;

    int n_checks = 0;
    int n_errors = 0;

    irom_arbiter #(.ROM_AW(17)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dp_req(dp_req), .dp_addr(dp_addr),
        .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid), .dp_rdata(dp_rdata), .dp_err(dp_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_model(input logic [31:0] a);
        if (a == 32'h10) return 32'h3401_1100;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign rom_inst = rom_model(rom_addr);

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        if_req = 1'b1;
        dp_req = 1'b1;
        #2;
        n_checks++; if (if_gnt !== 1'b0 || dp_gnt !== 1'b0) begin n_errors++; $display("FAIL reset_gnt: got %b%b expected 00", if_gnt, dp_gnt); end
        n_checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'd0) begin n_errors++; $display("FAIL reset_rom: got ce=%b addr=%h expected 0/0", rom_ce, rom_addr); end
        n_checks++; if ({if_rvalid, dp_rvalid, if_err, dp_err} !== 4'b0 || if_rdata !== 32'd0 || dp_rdata !== 32'd0) begin n_errors++; $display("FAIL reset_resp: got %b%b%b%b %h %h expected zeros", if_rvalid, dp_rvalid, if_err, dp_err, if_rdata, dp_rdata); end
        if_req = 1'b0;
        dp_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_fetch;
        next_cycle();
        if_req = 1'b1;
        if_addr = 32'h10;
        #1;
        n_checks++; if (if_gnt !== 1'b1 || dp_gnt !== 1'b0) begin n_errors++; $display("FAIL single_gnt: got %b%b expected 10", if_gnt, dp_gnt); end
        next_cycle();
        if_req = 1'b0;
        #1;
        n_checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h10) begin n_errors++; $display("FAIL single_rom: got ce=%b addr=%h expected 1/00000010", rom_ce, rom_addr); end
        n_checks++; if (if_rvalid !== 1'b0) begin n_errors++; $display("FAIL single_early: got rvalid=%b expected 0", if_rvalid); end
        next_cycle();
        #1;
        n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h3401_1100 || if_err !== 1'b0 || dp_rvalid !== 1'b0) begin n_errors++; $display("FAIL single_resp: got v=%b d=%h e=%b dpv=%b expected 1/34011100/0/0", if_rvalid, if_rdata, if_err, dp_rvalid); end
        next_cycle();
        #1;
        n_checks++; if (if_rvalid !== 1'b0) begin n_errors++; $display("FAIL single_pulse: got rvalid=%b expected 0", if_rvalid); end
    endtask

    task automatic test_contention;
        logic        exp_dp [6];
        logic [31:0] exp_a [6];
        int          n_dp;
        n_dp = 0;
        for (int i = 0; i < 6; i++) begin
`ifdef IROM_ARB_RR_EN
            exp_dp[i] = (i % 2) == 1;
`else
            exp_dp[i] = 1'b0;
`endif
            exp_a[i] = exp_dp[i] ? 32'h200 + 32'(4 * i) : 32'h100 + 32'(4 * i);
        end
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if_req = (i < 6);
            dp_req = (i < 6);
            if_addr = 32'h100 + 32'(4 * i);
            dp_addr = 32'h200 + 32'(4 * i);
            #1;
            if (i < 6) begin
                if (dp_gnt === 1'b1) n_dp++;
                n_checks++; if (if_gnt !== ~exp_dp[i] || dp_gnt !== exp_dp[i]) begin n_errors++; $display("FAIL contend_gnt[%0d]: got if=%b dp=%b expected if=%b dp=%b", i, if_gnt, dp_gnt, ~exp_dp[i], exp_dp[i]); end
            end
            if (i >= 2) begin
                if (exp_dp[i-2]) begin
                    n_checks++; if (dp_rvalid !== 1'b1 || if_rvalid !== 1'b0 || dp_rdata !== rom_model(exp_a[i-2])) begin n_errors++; $display("FAIL contend_resp[%0d]: got dpv=%b ifv=%b d=%h expected 1/0/%h", i-2, dp_rvalid, if_rvalid, dp_rdata, rom_model(exp_a[i-2])); end
                end else begin
                    n_checks++; if (if_rvalid !== 1'b1 || dp_rvalid !== 1'b0 || if_rdata !== rom_model(exp_a[i-2])) begin n_errors++; $display("FAIL contend_resp[%0d]: got ifv=%b dpv=%b d=%h expected 1/0/%h", i-2, if_rvalid, dp_rvalid, if_rdata, rom_model(exp_a[i-2])); end
                end
            end
        end
`ifdef IROM_ARB_RR_EN
        n_checks++; if (n_dp != 3) begin n_errors++; $display("FAIL contend_dp_count: got %0d expected 3", n_dp); end
`else
        n_checks++; if (n_dp != 0) begin n_errors++; $display("FAIL contend_dp_count: got %0d expected 0", n_dp); end
`endif
    endtask

    task automatic test_errors;
        next_cycle();
        dp_req = 1'b1;
        dp_addr = 32'h6;
        #1;
        n_checks++; if (dp_gnt !== 1'b1) begin n_errors++; $display("FAIL err_mis_gnt: got %b expected 1", dp_gnt); end
        next_cycle();
        dp_req = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h0008_0000;
        #1;
        n_checks++; if (rom_ce !== 1'b0) begin n_errors++; $display("FAIL err_mis_ce: got %b expected 0", rom_ce); end
        n_checks++; if (if_gnt !== 1'b1) begin n_errors++; $display("FAIL err_oor_gnt: got %b expected 1", if_gnt); end
        next_cycle();
        if_req = 1'b0;
        #1;
        n_checks++; if (dp_rvalid !== 1'b1 || dp_err !== 1'b1 || dp_rdata !== 32'd0) begin n_errors++; $display("FAIL err_mis_resp: got v=%b e=%b d=%h expected 1/1/0", dp_rvalid, dp_err, dp_rdata); end
        n_checks++; if (rom_ce !== 1'b0) begin n_errors++; $display("FAIL err_oor_ce: got %b expected 0", rom_ce); end
        next_cycle();
        #1;
        n_checks++; if (if_rvalid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'd0) begin n_errors++; $display("FAIL err_oor_resp: got v=%b e=%b d=%h expected 1/1/0", if_rvalid, if_err, if_rdata); end
    endtask

    task automatic test_flush;
        next_cycle();
        if_req = 1'b1;
        if_addr = 32'h20;
        #1;
        n_checks++; if (if_gnt !== 1'b1) begin n_errors++; $display("FAIL flush_first_gnt: got %b expected 1", if_gnt); end
        next_cycle();
        if_flush = 1'b1;
        dp_req = 1'b1;
        dp_addr = 32'h40;
        #1;
        n_checks++; if (if_gnt !== 1'b0 || dp_gnt !== 1'b1) begin n_errors++; $display("FAIL flush_gnt: got if=%b dp=%b expected 0/1", if_gnt, dp_gnt); end
        next_cycle();
        if_req = 1'b0;
        if_flush = 1'b0;
        dp_req = 1'b0;
        #1;
        n_checks++; if (if_rvalid !== 1'b0) begin n_errors++; $display("FAIL flush_killed: got if_rvalid=%b expected 0", if_rvalid); end
        n_checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h40) begin n_errors++; $display("FAIL flush_dp_rom: got ce=%b addr=%h expected 1/00000040", rom_ce, rom_addr); end
        next_cycle();
        #1;
        n_checks++; if (dp_rvalid !== 1'b1 || dp_err !== 1'b0 || dp_rdata !== rom_model(32'h40) || if_rvalid !== 1'b0) begin n_errors++; $display("FAIL flush_dp_resp: got v=%b e=%b d=%h ifv=%b expected 1/0/%h/0", dp_rvalid, dp_err, dp_rdata, if_rvalid, rom_model(32'h40)); end
    endtask

    task automatic test_reset_mid;
        next_cycle();
        if_req = 1'b1;
        if_addr = 32'h24;
        next_cycle();
        if_req = 1'b0;
        next_cycle();
        #1;
        n_checks++; if (if_rdata !== rom_model(32'h24)) begin n_errors++; $display("FAIL rstmid_setup: got %h expected %h", if_rdata, rom_model(32'h24)); end
        if_req = 1'b1;
        dp_req = 1'b1;
        if_addr = 32'h30;
        dp_addr = 32'h34;
        next_cycle();
        if_req = 1'b0;
        dp_req = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'd0) begin n_errors++; $display("FAIL rstmid_rom: got ce=%b addr=%h expected 0/0", rom_ce, rom_addr); end
        n_checks++; if (if_rvalid !== 1'b0 || dp_rvalid !== 1'b0 || if_rdata !== 32'd0 || dp_rdata !== 32'd0) begin n_errors++; $display("FAIL rstmid_resp: got %b%b %h %h expected 00 0 0", if_rvalid, dp_rvalid, if_rdata, dp_rdata); end
        n_checks++; if (dp_gnt !== 1'b0) begin n_errors++; $display("FAIL rstmid_gnt: got %b expected 0", dp_gnt); end
        dp_req = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        n_checks++; if (if_rvalid !== 1'b0 || dp_rvalid !== 1'b0) begin n_errors++; $display("FAIL rstmid_drop: got %b%b expected 00", if_rvalid, dp_rvalid); end
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        if_req = 1'b1;
        dp_req = 1'b1;
        #1;
        n_checks++; if (if_gnt !== 1'b1 || dp_gnt !== 1'b0) begin n_errors++; $display("FAIL rstmid_first_contest: got if=%b dp=%b expected 1/0", if_gnt, dp_gnt); end
        next_cycle();
        if_req = 1'b0;
        dp_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_errors();
        test_flush();
        test_reset_mid();
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
